// File: rtl/run_monitor_if.sv
// rtl/run_monitor_if.sv - core data-memory store bus observed by the run monitor
interface run_monitor_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData
    );

    modport slave (
        input MemWrite,
        input DataAdr,
        input WriteData
    );
endinterface

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - core reset sequencer and PASS/FAIL store-convention run checker
module run_monitor #(
    parameter int          RESET_CYCLES   = 3,
    parameter int          TIMEOUT_CYCLES = 50,
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    run_monitor_if.slave     bus,
    output logic             core_reset,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] store_count
);

    localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_BADDATA = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  store_count_q, store_count_d;

    // MemWrite gates the compares so an undriven address/data bus is harmless.
    logic store_evt;
    logic pass_addr_hit;
    logic pass_data_ok;
    logic timeout_hit;

    always_comb begin
        store_evt     = (bus.MemWrite == 1'b1);
        pass_addr_hit = store_evt && (bus.DataAdr == PASS_ADDR);
        pass_data_ok  = pass_addr_hit && (bus.WriteData == PASS_DATA);
        timeout_hit   = (cycle_count_q == TIMEOUT_LAST);
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        core_reset_d  = core_reset_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        store_count_d = store_count_q;

        case (state_q)
            S_HOLD: begin
                core_reset_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = S_RUN;
                    hold_cnt_d   = '0;
                    core_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            S_RUN: begin
                core_reset_d = 1'b0;
                if (cycle_count_q != CNT_MAX) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                if (store_evt && (store_count_q != CNT_MAX)) begin
                    store_count_d = store_count_q + CNT_W'(1);
                end
                // A PASS_ADDR store on the timeout cycle takes precedence.
                if (pass_addr_hit) begin
                    done_d = 1'b1;
                    if (pass_data_ok) begin
                        state_d     = S_PASS;
                        pass_d      = 1'b1;
                        fail_code_d = FC_NONE;
                    end else begin
                        state_d     = S_FAIL;
                        pass_d      = 1'b0;
                        fail_code_d = FC_BADDATA;
                    end
                end else if (timeout_hit) begin
                    state_d     = S_FAIL;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = FC_TIMEOUT;
                end
            end

            S_PASS, S_FAIL: begin
                core_reset_d = 1'b0;
            end

            default: begin
                state_d      = S_HOLD;
                hold_cnt_d   = '0;
                core_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            core_reset_q  <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_code_q   <= FC_NONE;
            cycle_count_q <= '0;
            store_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            core_reset_q  <= core_reset_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            store_count_q <= store_count_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign store_count = store_count_q;

endmodule
